// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding, port indices and default memory size for the dmem arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;
  localparam int MEM_WORDS_DEF = 200;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; on a tie the port that did not win last time wins
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);
  always_comb begin
    valid  = req0 | req1;
    winner = (req0 & req1) ? ~last_gnt : req1;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between CPU (port 0) and DMA (port 1), one access per 3 cycles.
// Define DMEM_ARB_RANGE_CHK_EN to also flag word addresses >= MEM_WORDS as errors.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int AW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [31:0]   wdata0,
  output logic          ack0,
  output logic [31:0]   rdata0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata1,
  output logic          ack1,
  output logic [31:0]   rdata1,
  output logic          err1,
  output logic          mem_we,
  output logic [AW-1:0] mem_add,
  output logic [31:0]   mem_data,
  input  logic [31:0]   mem_rd
);
`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam logic RANGE_CHK = 1'b1;
`else
  localparam logic RANGE_CHK = 1'b0;
`endif
  state_t state, state_nxt;
  logic gnt, last_gnt, bad, rd;
  logic valid, winner, we_w, bad_w, resp;
  logic [AW-1:0] addr_w;
  logic [31:0] wdata_w;
  rr_arb2 u_arb (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .valid    (valid),
    .winner   (winner)
  );
  // Outputs decode from RESP so rdata can pass the registered memory read straight through.
  always_comb begin
    addr_w    = winner ? addr1 : addr0;
    wdata_w   = winner ? wdata1 : wdata0;
    we_w      = winner ? we1 : we0;
    bad_w     = (addr_w[1:0] != 2'b00) | (RANGE_CHK & ({2'b00, addr_w[AW-1:2]} >= AW'(MEM_WORDS)));
    state_nxt = (state == IDLE) ? (valid ? ISSUE : IDLE) : (state == ISSUE) ? RESP : IDLE;
    resp      = state == RESP;
    ack0      = resp & (gnt == PORT_CPU);
    ack1      = resp & (gnt == PORT_DMA);
    err0      = ack0 & bad;
    err1      = ack1 & bad;
    rdata0    = (ack0 & rd & ~bad) ? mem_rd : 32'h0;
    rdata1    = (ack1 & rd & ~bad) ? mem_rd : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we   <= 1'b0;
      mem_add  <= '0;
      mem_data <= '0;
      gnt      <= PORT_CPU;
      last_gnt <= PORT_DMA;
      bad      <= 1'b0;
      rd       <= 1'b0;
    end else if (state == IDLE && valid) begin
      gnt      <= winner;
      last_gnt <= winner;
      mem_add  <= addr_w;
      mem_data <= wdata_w;
      mem_we   <= we_w & ~bad_w;
      bad      <= bad_w;
      rd       <= ~we_w;
    end else begin
      mem_we <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors against a behavioural registered-read memory
module tb_dmem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic ack0, err0, ack1, err1, mem_we;
  logic [31:0] rdata0, rdata1, mem_add, mem_data;
  logic [31:0] mem_rd = 32'h0;
  logic [31:0] mem [256];
  int we_cnt = 0, both_cnt = 0, n_vec = 0, n_err = 0;
  dmem_arbiter #(.MEM_WORDS(200), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_we(mem_we), .mem_add(mem_add), .mem_data(mem_data), .mem_rd(mem_rd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) mem[mem_add[9:2]] <= mem_data;
    mem_rd <= mem[mem_add[9:2]];
  end
  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (ack0 && ack1) both_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input bit p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask
  task automatic access(input bit p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic e, output int wes);
    int w0;
    w0 = we_cnt;
    drive(p, 1'b1, w, a, d);
    lat = -1; rd = 'x; e = 1'bx;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (p ? ack1 : ack0) begin
        lat = c; rd = p ? rdata1 : rdata0; e = p ? err1 : err0;
      end
    end
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    wes = we_cnt - w0;
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask
  initial begin
    int lat, wes, k, lat0, lat1, acks;
    logic [31:0] rd, r1;
    logic e;
    int ports [4], cycs [4];
    logic [31:0] dats [4];
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_add", mem_add, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_acks", {ack0, ack1, err0, err1}, 0);
    chk("rst_rdata", rdata0 | rdata1, 0);
    // reset while a port 0 write is in ISSUE
    drive(0, 1, 1, 32'h20, 32'h0000CAFE);
    @(posedge clk); #1;
    chk("miss_issue_we", mem_we, 1);
    reset = 1'b1; drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("miss_out", {mem_we, ack0, ack1, err0, err1}, 0);
    chk("miss_add", mem_add | mem_data, 0);
    acks = 0;
    repeat (4) begin @(posedge clk); #1; if (ack0 || ack1) acks++; end
    chk("miss_no_ack", acks, 0);
    // port 0 write then read
    access(0, 1, 32'h10, 32'hDEADBEEF, lat, rd, e, wes);
    chk("w0_lat", lat, 2); chk("w0_err", e, 0); chk("w0_we_cnt", wes, 1); chk("w0_rdata", rd, 0);
    access(0, 0, 32'h10, 32'h0, lat, rd, e, wes);
    chk("r0_lat", lat, 2); chk("r0_err", e, 0); chk("r0_we_cnt", wes, 0); chk("r0_rdata", rd, 32'hDEADBEEF);
    // continuous contention from reset
    pulse_reset();
    drive(0, 1, 0, 32'h04, 0); drive(1, 1, 0, 32'h08, 0);
    k = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if ((ack0 || ack1) && k < 4) begin
        ports[k] = ack1 ? 1 : 0; cycs[k] = c; dats[k] = ack1 ? rdata1 : rdata0; k++;
      end
    end
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk); #1;
    chk("rr_count", k, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_port%0d", i), ports[i], i % 2);
      chk($sformatf("rr_cyc%0d", i), cycs[i], 2 + 3 * i);
      chk($sformatf("rr_data%0d", i), dats[i], (i % 2) ? 32'hA000_0002 : 32'hA000_0001);
    end
    // misaligned port 1 write must not reach memory
    access(1, 1, 32'h0E, 32'h12345678, lat, rd, e, wes);
    chk("mis_lat", lat, 2); chk("mis_err", e, 1); chk("mis_we_cnt", wes, 0);
    access(1, 0, 32'h0C, 32'h0, lat, rd, e, wes);
    chk("mis_rb_err", e, 0); chk("mis_rb_data", rd, 32'hA000_0003);
    access(0, 0, 32'h11, 32'h0, lat, rd, e, wes);
    chk("mis_rd_err", e, 1); chk("mis_rd_data", rd, 0);
    // word 200: out of range only when the range check is built in
    access(0, 1, 32'h320, 32'h55, lat, rd, e, wes);
    chk("rng_lat", lat, 2);
`ifdef DMEM_ARB_RANGE_CHK_EN
    chk("rng_err", e, 1); chk("rng_we_cnt", wes, 0);
`else
    chk("rng_err", e, 0); chk("rng_we_cnt", wes, 1);
`endif
    // port 1 arrives while port 0 is in ISSUE
    drive(0, 1, 0, 32'h10, 0);
    lat0 = -1; lat1 = -1; r1 = 'x; rd = 'x;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(1, 1, 0, 32'h08, 0);
      if (ack0 && lat0 < 0) begin lat0 = c; rd = rdata0; drive(0, 0, 0, 0, 0); end
      if (ack1 && lat1 < 0) begin lat1 = c; r1 = rdata1; drive(1, 0, 0, 0, 0); end
    end
    chk("ovl_lat0", lat0, 2); chk("ovl_lat1", lat1, 5);
    chk("ovl_data0", rd, 32'hDEADBEEF); chk("ovl_data1", r1, 32'hA000_0002);
    chk("never_both_ack", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
